// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// It shares one external hex decoder across the digits and swaps the displayed value only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    input  logic [6:0]  seg_in,
    output logic [6:0]  seg_out,
    output logic        dp,
    output logic [3:0]  an,
    output logic        pending
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [15:0]      disp_reg_q, disp_reg_d;
    logic [3:0]       disp_dp_q, disp_dp_d;
    logic [15:0]      pend_reg_q, pend_reg_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pending_q, pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             frame_end;
    logic             digit_off;
    logic [3:0]       lz_blank;

    always_comb begin
        slot_end    = (tick_cnt_q == CNT_W'(REFRESH_DIV - 1));
        frame_end   = slot_end && (digit_idx_q == 2'd3);
        tick_cnt_d  = slot_end ? '0 : tick_cnt_q + CNT_W'(1);
        digit_idx_d = slot_end ? digit_idx_q + 2'd1 : digit_idx_q;

        bcd = disp_reg_q[{digit_idx_q, 2'b00} +: 4];

        // A digit is a leading zero only if it and every digit above it are zero.
        lz_blank[3] = (disp_reg_q[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (disp_reg_q[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (disp_reg_q[7:4] == 4'h0);
        lz_blank[0] = 1'b0;

        digit_off = (tick_cnt_q < CNT_W'(BLANK_CYC)) ||
                    (blank_lz && lz_blank[digit_idx_q]);

        an_d  = 4'b1111;
        seg_d = 7'b0000000;
        dp_d  = 1'b0;
        if (!digit_off) begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = seg_in;
            dp_d  = disp_dp_q[digit_idx_q];
        end

        disp_reg_d = disp_reg_q;
        disp_dp_d  = disp_dp_q;
        pend_reg_d = pend_reg_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;
        // Transfer reads the old pending value; a coincident load re-arms pending.
        if (frame_end && pending_q) begin
            disp_reg_d = pend_reg_q;
            disp_dp_d  = pend_dp_q;
            pending_d  = 1'b0;
        end
        if (load) begin
            pend_reg_d = value;
            pend_dp_d  = dp_in;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            disp_reg_q  <= 16'h0000;
            disp_dp_q   <= 4'h0;
            pend_reg_q  <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pending_q   <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b0000000;
            dp_q        <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            digit_idx_q <= digit_idx_d;
            disp_reg_q  <= disp_reg_d;
            disp_dp_q   <= disp_dp_d;
            pend_reg_q  <= pend_reg_d;
            pend_dp_q   <= pend_dp_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg_out = seg_q;
    assign dp      = dp_q;
    assign pending = pending_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares one `hexa_to_7` decoder instance, external to this block, across four digits. A 16-bit value is accepted through a load interface and held in a pending register. The value is transferred to the display register only at a scan-frame boundary, so no frame shows a mix of old and new digits. Each digit slot starts with an anti-ghosting blank gap, and optional leading-zero blanking is supported. The block sits between the datapath result registers and the board display pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off. Requires 1 ≤ BLANK_CYC < REFRESH_DIV.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `load` input, 1 bit: one-cycle strobe that captures `value` and `dp_in`.
- `value` input, 16 bits: four hex digits. Digit i is value[4i+3:4i]; digit 0 is the rightmost.
- `dp_in` input, 4 bits: decimal point per digit, active-high.
- `blank_lz` input, 1 bit: enables leading-zero blanking. Sampled every cycle.
- `bcd` output, 4 bits: nibble for the current digit, driven to the external decoder. Combinational from the state.
- `seg_in` input, 7 bits: decoder output {a,b,c,d,e,f,g}, active-high.
- `seg_out` output, 7 bits: registered, active-high segments to the pins.
- `dp` output, 1 bit: registered decimal point, active-high.
- `an` output, 4 bits: registered anode enables, active-low, one-hot-low or all-ones.
- `pending` output, 1 bit: registered. High while a loaded value awaits transfer.

## Operation
- **Reset values:** `tick_cnt`=0, `digit_idx`=0, `disp_reg`=16'h0000, `disp_dp`=0, `pend_reg`=0, `pend_dp`=0, `pending`=0, `an`=4'b1111, `seg_out`=7'b0000000, `dp`=0.
- **Slot counter:** `tick_cnt` counts 0..REFRESH_DIV-1 and wraps. On wrap, `digit_idx` increments mod 4 (3 goes to 0). One frame is 4·REFRESH_DIV cycles.
- **Phases within a slot:** BLANK phase while tick_cnt < BLANK_CYC. ON phase otherwise.
- **Decoder drive:** `bcd` = disp_reg nibble selected by `digit_idx`, in every phase.
- **Digit blanking:** with `blank_lz`=1, digit i (i = 3, 2, 1) is blanked when it and every higher digit are 0. Digit 0 is never blanked.
- **Registered outputs, ON phase, digit not blanked:**
  - an = ~(4'b0001 << digit_idx)
  - seg_out = seg_in
  - dp = disp_dp[digit_idx]
- **Registered outputs, BLANK phase or blanked digit:** an=4'b1111, seg_out=0, dp=0.
- **Load:** when `load`=1, pend_reg ← value, pend_dp ← dp_in, pending ← 1. A load while already pending overwrites; the latest value wins.
- **Frame transfer:** occurs on the frame-end cycle, defined as tick_cnt==REFRESH_DIV-1 and digit_idx==3. If `pending`=1 on that cycle:
  - disp_reg ← pend_reg, disp_dp ← pend_dp.
  - pending ← 0.
- **Load coinciding with the frame-end cycle:** the transfer uses the old pend_reg. The new value is captured into pend_reg and `pending` stays 1 until the next frame end.
- **Reset mid-frame:** everything returns to the reset values on the next edge. A pending load is discarded.

## Timing
- Registered outputs lag the (tick_cnt, digit_idx) state by exactly one clock.
- Take the first edge with reset=0 as edge 1. Then `an`=4'b1110 first appears after edge BLANK_CYC+1 and holds for REFRESH_DIV−BLANK_CYC cycles.
- Load-to-display latency:
  - `pending` rises the cycle after `load`.
  - `pending` falls the cycle after the next frame-end cycle.
  - The new value is first visible in digit 0's ON phase of the following frame. Worst case is 4·REFRESH_DIV + BLANK_CYC + 2 cycles.
- `seg_in` must settle within the same cycle as `bcd`. The decoder is purely combinational, and there is no pipeline stage inside this block.
- At most one anode is low in any cycle. Between consecutive digits, all anodes are high for at least BLANK_CYC cycles.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYC=2.
1. **Reset:** hold reset for 3 cycles. Then an=4'b1111, seg_out=0, dp=0, pending=0. After release, an=4'b1110 from edge 3 to edge 8, with bcd=0 and seg_out=7'b1111110.
2. **Load and transfer:** load value=16'h1A3F, dp_in=4'b0100 at cycle 5.
   - pending=1 at cycle 6.
   - Display unchanged until the frame end at cycle 31; pending=0 at cycle 32.
   - Next frame shows digits 0–3 as seg 1000111, 1111001 with dp=1 on digit 2, 1110111, 0110000.
   - Digit 2's dp=1 is from dp_in bit 2.
3. **Leading-zero blanking:** blank_lz=1, value=16'h0050.
   - Digit 3 slot: an=4'b1111 for the whole slot.
   - Digit 2 slot: an=4'b1111 for the whole slot.
   - Digit 1 slot: an=4'b1101, showing "5".
   - Digit 0 slot: an=4'b1110, showing "0".
   - With value=16'h0000, only digit 0 lights.
4. **Load on frame end:** load value A, then load value B exactly on the frame-end cycle.
   - A is displayed in the next frame.
   - pending stays 1.
   - B is displayed one frame later.
5. **Overwrite:** load 16'h1111 then 16'h2222 within one frame. Only 16'h2222 ever appears, and there is no torn frame.
6. **Reset mid-operation:** assert reset during digit 2's ON phase while pending=1. All outputs return to their reset values the next cycle, disp_reg=0, and the pending value is never displayed.
